gcd_stream_engine: RTL and testbench
====================================

// Module: gcd_stream_engine
// PURPOSE
//  Parametrised, handshaked GCD engine; successor to the start-pulse subtractive GCD unit.
//  Accepts one operand pair per transaction on a valid/ready input port.
//  Per-transaction mode: subtractive Euclid or binary (Stein).
//  Returns the GCD, an iteration count and a 0/0 flag on a valid/ready output port.
//  Sits between a command source and a result consumer; both may stall.
// PARAMETERS
//  WIDTH  16  operand/result width in bits (>=2)
//  CNT_W  16  iteration-counter width in bits (>=1)
// PORTS
//  clk         in   1      clock, all state on rising edge
//  rst         in   1      asynchronous, active-high reset
//  in_valid    in   1      operand pair + mode valid
//  in_ready    out  1      engine idle, can accept
//  in_a        in   WIDTH  operand A, unsigned
//  in_b        in   WIDTH  operand B, unsigned
//  in_mode     in   1      0 = subtractive, 1 = binary (Stein)
//  out_valid   out  1      result valid, held until taken
//  out_ready   in   1      consumer takes result
//  out_gcd     out  WIDTH  gcd(in_a, in_b)
//  out_cycles  out  CNT_W  CALC cycles used, saturating
//  out_zero    out  1      1 iff in_a==0 and in_b==0
//  busy        out  1      state != IDLE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, all datapath regs 0.
//   Reset outputs: out_valid=0, busy=0, out_gcd=0, out_cycles=0, out_zero=0, in_ready=1.
//   Reset mid-CALC/DONE discards the transaction; no result is produced.
//  FSM: IDLE -> CALC -> DONE -> IDLE; in_ready = (state==IDLE); out_valid = (state==DONE).
//  IDLE: in_valid & in_ready at edge -> latch a, b, mode; k=0; cnt=0.
//   If a==0 or b==0: go directly to DONE.
//    out_gcd = a|b (nonzero operand or 0); out_cycles=0; out_zero = (a==0 && b==0).
//   Otherwise go to CALC.
//  CALC: one step per cycle; cnt increments every CALC cycle and saturates at all-ones.
//   Equal (both modes): if a==b, latch out_gcd (mode0: a; mode1: a<<k), go to DONE.
//    The equality cycle itself is counted.
//   Mode 0 step: a>b -> a=a-b; else b=b-a.
//   Mode 1 step (priority order):
//    both even    -> a>>=1, b>>=1, k++
//    a even       -> a>>=1
//    b even       -> b>>=1
//    both odd a>b -> a=(a-b)>>1
//    both odd a<b -> b=(b-a)>>1
//   k width = clog2(WIDTH)+1. a<<k never exceeds WIDTH bits (equals true gcd).
//   All arithmetic unsigned WIDTH-bit; subtraction never underflows (larger minus smaller).
//  DONE: out_gcd/out_cycles/out_zero stable while out_valid=1.
//   out_valid & out_ready -> IDLE.
//   in_valid is ignored (in_ready=0) in CALC and DONE. No bypass: >=1 idle cycle between results.
//  Latency (acceptance edge to first out_valid cycle): zero operand = 1 cycle; else cnt+1 cycles.
//  in_mode, in_a, in_b are sampled only at the acceptance edge; later changes have no effect.
// TESTING
//  1 mode0 A=48 B=18 -> out_gcd=6, out_cycles=5, out_zero=0.
//  2 mode1 A=48 B=18 -> out_gcd=6, out_cycles=6 (k=1 path).
//  3 A=0 B=35 -> 35, cycles=0, out_zero=0, out_valid one cycle after accept.
//    A=0 B=0 -> 0, out_zero=1.
//  4 Backpressure: out_ready=0 for 10 cycles after out_valid.
//    -> outputs stable; in_ready=0; in_valid pulses ignored; release -> IDLE next edge.
//  5 rst pulse mid-CALC (mode0 A=1000 B=3).
//    -> out_valid never rises; in_ready=1; next op A=12 B=8 -> 4.
//  6 WIDTH=8 CNT_W=4 mode0 A=255 B=1 -> out_gcd=1, out_cycles=15 (saturated).
//    Same pair in mode1 -> 1. Random 1000-pair sweep, both modes, vs reference model.

Source files
------------

// File: rtl/gcd_stream_engine.sv
// Handshaked GCD engine: per-transaction subtractive Euclid or binary (Stein).
// One step per CALC cycle; the result is held on the output port until it is taken.
module gcd_stream_engine #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic [CNT_W-1:0] out_cycles,
    output logic             out_zero,
    output logic             busy
);

    localparam int KW = $clog2(WIDTH) + 1;
    localparam logic [KW-1:0]    K_ONE   = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] a, b, gcd_r;
    logic [KW-1:0]    k;
    logic [CNT_W-1:0] cnt;
    logic             mode;
    logic             zero_r;

    logic             accept;
    logic             in_zero;
    logic             eq;
    logic [WIDTH-1:0] a_minus_b, b_minus_a;

    assign accept    = in_valid && (state == IDLE);
    assign in_zero   = (in_a == '0) || (in_b == '0);
    assign eq        = (a == b);
    assign a_minus_b = a - b;
    assign b_minus_a = b - a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = in_zero ? DONE : CALC;
            CALC:    if (eq) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a      <= '0;
            b      <= '0;
            k      <= '0;
            cnt    <= '0;
            mode   <= 1'b0;
            gcd_r  <= '0;
            zero_r <= 1'b0;
        end else if (state == IDLE) begin
            if (accept) begin
                a      <= in_a;
                b      <= in_b;
                mode   <= in_mode;
                k      <= '0;
                cnt    <= '0;
                gcd_r  <= in_a | in_b;
                zero_r <= (in_a == '0) && (in_b == '0);
            end
        end else if (state == CALC) begin
            if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
            if (eq) begin
                // Stein restores the common power of two removed earlier
                gcd_r <= mode ? (a << k) : a;
            end else if (!mode) begin
                if (a > b) a <= a_minus_b;
                else       b <= b_minus_a;
            end else begin
                unique case (1'b1)
                    (!a[0] && !b[0]): begin
                        a <= a >> 1;
                        b <= b >> 1;
                        k <= k + K_ONE;
                    end
                    (!a[0] && b[0]): a <= a >> 1;
                    (a[0] && !b[0]): b <= b >> 1;
                    (a[0] && b[0] && (a > b)): a <= a_minus_b >> 1;
                    default: b <= b_minus_a >> 1;
                endcase
            end
        end
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign out_gcd    = gcd_r;
    assign out_cycles = cnt;
    assign out_zero   = zero_r;

endmodule

// File: tb/tb_gcd_stream_engine.sv
// Bench for gcd_stream_engine (WIDTH=8, CNT_W=4): vector table,
// handshake/reset corner sequences and a random sweep against a model.
module tb_gcd_stream_engine;

    localparam int W  = 8;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int BOUND = 400;

    logic          clk = 0;
    logic          rst = 1;
    logic          in_valid = 0;
    logic          in_ready;
    logic [W-1:0]  in_a = 0;
    logic [W-1:0]  in_b = 0;
    logic          in_mode = 0;
    logic          out_valid;
    logic          out_ready = 0;
    logic [W-1:0]  out_gcd;
    logic [CW-1:0] out_cycles;
    logic          out_zero;
    logic          busy;

    int compared = 0;
    int mismatched = 0;

    gcd_stream_engine #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_gcd(out_gcd), .out_cycles(out_cycles),
        .out_zero(out_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a; int b; bit m;
        int gcd; int cyc; bit zero; int lat;
    } vec_t;

    task automatic check(input string name, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Number of CALC cycles the step rules take, unsaturated
    function automatic int ref_steps(input int a, input int b, input bit m);
        int n = 0;
        if (a == 0 || b == 0) return 0;
        while (1) begin
            n++;
            if (a == b) return n;
            if (!m) begin
                if (a > b) a -= b; else b -= a;
            end else if (a % 2 == 0 && b % 2 == 0) begin
                a /= 2; b /= 2;
            end else if (a % 2 == 0) a /= 2;
            else if (b % 2 == 0) b /= 2;
            else if (a > b) a = (a - b) / 2;
            else b = (b - a) / 2;
        end
        return n;
    endfunction

    task automatic accept(input int a, input int b, input bit m);
        int w = 0;
        while (!in_ready && w < BOUND) begin
            @(posedge clk); #1; w++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        in_a = a[W-1:0];
        in_b = b[W-1:0];
        in_mode = m;
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        in_a = W'($urandom);
        in_b = W'($urandom);
        in_mode = 1'($urandom);
    endtask

    task automatic wait_valid(output int waited);
        waited = 0;
        while (!out_valid && waited < BOUND) begin
            @(posedge clk); #1; waited++;
        end
        if (!out_valid) check("valid_timeout", 0, 1);
    endtask

    task automatic take();
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic run_op(input string tag, input int a, input int b, input bit m,
                          input int eg, input int ec, input bit ez, input int el);
        int w;
        accept(a, b, m);
        wait_valid(w);
        check({tag, "_gcd"}, int'(out_gcd), eg);
        check({tag, "_cycles"}, int'(out_cycles), ec);
        check({tag, "_zero"}, int'(out_zero), int'(ez));
        check({tag, "_latency"}, w, el);
        take();
        check({tag, "_idle_after"}, int'(in_ready), 1);
    endtask

    vec_t vt[9];

    initial begin
        int w, a, b, s, cnt_v;
        bit m;

        vt[0] = '{48, 18, 0, 6, 5, 0, 5};
        vt[1] = '{48, 18, 1, 6, 6, 0, 6};
        vt[2] = '{0, 35, 0, 35, 0, 0, 0};
        vt[3] = '{0, 0, 1, 0, 0, 1, 0};
        vt[4] = '{255, 1, 0, 1, 15, 0, 255};
        vt[5] = '{255, 1, 1, 1, 8, 0, 8};
        vt[6] = '{12, 8, 0, 4, 3, 0, 3};
        vt[7] = '{7, 0, 1, 7, 0, 0, 0};
        vt[8] = '{5, 5, 0, 5, 1, 0, 1};

        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_gcd", int'(out_gcd), 0);
        check("rst_cycles", int'(out_cycles), 0);
        check("rst_zero", int'(out_zero), 0);
        @(posedge clk); #1;
        rst = 0;

        foreach (vt[i])
            run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].m,
                   vt[i].gcd, vt[i].cyc, vt[i].zero, vt[i].lat);

        // Consumer stalls; new commands must be ignored meanwhile
        accept(48, 18, 0);
        wait_valid(w);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1;
            in_a = 8'd9;
            in_b = 8'd6;
            @(posedge clk); #1;
            in_valid = 0;
            check("bp_valid", int'(out_valid), 1);
            check("bp_gcd", int'(out_gcd), 6);
            check("bp_cycles", int'(out_cycles), 5);
            check("bp_in_ready", int'(in_ready), 0);
        end
        take();
        check("bp_release_valid", int'(out_valid), 0);
        check("bp_release_ready", int'(in_ready), 1);
        check("bp_release_busy", int'(busy), 0);

        // Reset in the middle of a long calculation
        accept(200, 3, 0);
        repeat (5) @(posedge clk);
        #1;
        check("mid_busy", int'(busy), 1);
        #2 rst = 1;
        #2;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_ready", int'(in_ready), 1);
        check("mid_rst_cycles", int'(out_cycles), 0);
        rst = 0;
        cnt_v = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (out_valid) cnt_v++;
        end
        check("mid_no_result", cnt_v, 0);
        run_op("post_rst", 12, 8, 0, 4, 3, 0, 3);

        for (int i = 0; i < 1000; i++) begin
            a = (i % 50 == 0) ? 0 : int'($urandom_range(0, 255));
            b = (i % 70 == 3) ? 0 : int'($urandom_range(1, 255));
            m = 1'($urandom);
            s = ref_steps(a, b, m);
            accept(a, b, m);
            wait_valid(w);
            check("rnd_gcd", int'(out_gcd), ref_gcd(a, b));
            check("rnd_cycles", int'(out_cycles), (s > CMAX) ? CMAX : s);
            check("rnd_zero", int'(out_zero), (a == 0 && b == 0) ? 1 : 0);
            check("rnd_latency", w, s);
            take();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
